// File: rtl/rgb_layer_mux_if.sv
// rgb_layer_mux_if
// Groups the pixel-path signals of rgb_layer_mux into a single bundle.
//   master : the pixel source. It drives the i_* signals and observes the o_* signals.
//   slave  : the mux itself. It reads the i_* signals and drives the o_* signals.
// Signals:
//   i_valid, i_blank, i_vsync, i_mode, i_sel, i_rgb (N_CH*W_RGB), i_en (N_CH),
//   i_key_en, i_blink_mask (N_CH), i_bg_rgb (W_RGB)
//   o_valid, o_rgb (W_RGB), o_src (W_SEL), o_hit, o_phase
interface rgb_layer_mux_if #(
  parameter int N_CH  = 9,
  parameter int W_RGB = 12,
  parameter int W_SEL = 4
);
  logic                    i_valid;
  logic                    i_blank;
  logic                    i_vsync;
  logic                    i_mode;
  logic [W_SEL-1:0]        i_sel;
  logic [N_CH*W_RGB-1:0]   i_rgb;
  logic [N_CH-1:0]         i_en;
  logic                    i_key_en;
  logic [N_CH-1:0]         i_blink_mask;
  logic [W_RGB-1:0]        i_bg_rgb;
  logic                    o_valid;
  logic [W_RGB-1:0]        o_rgb;
  logic [W_SEL-1:0]        o_src;
  logic                    o_hit;
  logic                    o_phase;

  modport master (
    output i_valid, i_blank, i_vsync, i_mode, i_sel, i_rgb, i_en,
           i_key_en, i_blink_mask, i_bg_rgb,
    input  o_valid, o_rgb, o_src, o_hit, o_phase
  );

  modport slave (
    input  i_valid, i_blank, i_vsync, i_mode, i_sel, i_rgb, i_en,
           i_key_en, i_blink_mask, i_bg_rgb,
    output o_valid, o_rgb, o_src, o_hit, o_phase
  );
endinterface

// File: rtl/rgb_layer_mux.sv
// rgb_layer_mux
// Two-stage RGB layer selector that sits between the per-object ROMs and the VGA stage.
// There are two modes:
//   - mode 0 passes through the channel chosen by i_sel.
//   - mode 1 composites all channels by priority. The highest-index opaque channel wins.
// A channel is transparent when any of these is true:
//   - it is disabled;
//   - it matches the colour key while keying is enabled;
//   - it is blink-masked while the blink phase is 1.
// Ports:
//   i_pclk : pixel clock
//   i_rst  : asynchronous, active-high reset
//   bus    : rgb_layer_mux_if.slave, which carries the pixel inputs and the o_* results
module rgb_layer_mux #(
  parameter int               N_CH         = 9,
  parameter int               W_RGB        = 12,
  parameter int               W_SEL        = 4,
  parameter logic [W_RGB-1:0] KEY_RGB      = 12'hF0F,
  parameter int               BLINK_FRAMES = 16
) (
  input  logic           i_pclk,
  input  logic           i_rst,
  rgb_layer_mux_if.slave bus
);
  // A one-bit counter is still needed when BLINK_FRAMES = 1.
  // It then stays at 0, and the phase toggles on every vsync edge.
  localparam int W_CNT = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // ---------------- blink phase ----------------
  logic             vs_q;
  logic [W_CNT-1:0] blink_cnt_q;
  logic             phase_q;
  logic             vs_edge;

  assign vs_edge = bus.i_vsync & ~vs_q;

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      vs_q        <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      vs_q <= bus.i_vsync;
      if (vs_edge) begin
        if (blink_cnt_q == W_CNT'(BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------- stage 1 ----------------
  logic [N_CH-1:0] opaque_d;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_opaque
    logic [W_RGB-1:0] ch;
    assign ch = bus.i_rgb[gi*W_RGB +: W_RGB];
    assign opaque_d[gi] = bus.i_en[gi]
                        & ~(bus.i_key_en & (ch == KEY_RGB))
                        & ~(bus.i_blink_mask[gi] & phase_q);
  end

  logic [N_CH*W_RGB-1:0] s1_rgb_q;
  logic [N_CH-1:0]       s1_opaque_q;
  logic                  s1_mode_q;
  logic [W_SEL-1:0]      s1_sel_q;
  logic                  s1_blank_q;
  logic [W_RGB-1:0]      s1_bg_q;
  logic                  s1_valid_q;

  // The data registers load every cycle. Valid rides alongside as a plain qualifier.
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      s1_rgb_q    <= '0;
      s1_opaque_q <= '0;
      s1_mode_q   <= 1'b0;
      s1_sel_q    <= '0;
      s1_blank_q  <= 1'b0;
      s1_bg_q     <= '0;
      s1_valid_q  <= 1'b0;
    end else begin
      s1_rgb_q    <= bus.i_rgb;
      s1_opaque_q <= opaque_d;
      s1_mode_q   <= bus.i_mode;
      s1_sel_q    <= bus.i_sel;
      s1_blank_q  <= bus.i_blank;
      s1_bg_q     <= bus.i_bg_rgb;
      s1_valid_q  <= bus.i_valid;
    end
  end

  // ---------------- stage 2 ----------------
  logic [W_RGB-1:0] rgb_d;
  logic [W_SEL-1:0] src_d;
  logic             hit_d;

  always_comb begin
    rgb_d = '0;
    src_d = '0;
    hit_d = 1'b0;
    if (s1_mode_q) begin
      rgb_d = s1_bg_q;
      // Ascending scan: a later (higher-index) opaque channel overwrites earlier ones.
      for (int k = 0; k < N_CH; k++) begin
        if (s1_opaque_q[k]) begin
          rgb_d = s1_rgb_q[k*W_RGB +: W_RGB];
          src_d = W_SEL'(k);
          hit_d = 1'b1;
        end
      end
    end else begin
      // An out-of-range select matches no k, so the output keeps its zero defaults.
      for (int k = 0; k < N_CH; k++) begin
        if (s1_sel_q == W_SEL'(k)) begin
          if (s1_opaque_q[k]) begin
            rgb_d = s1_rgb_q[k*W_RGB +: W_RGB];
            src_d = W_SEL'(k);
            hit_d = 1'b1;
          end else begin
            rgb_d = s1_bg_q;
          end
        end
      end
    end
    if (s1_blank_q) begin
      rgb_d = '0;
      src_d = '0;
      hit_d = 1'b0;
    end
  end

  logic             valid_q;
  logic [W_RGB-1:0] rgb_q;
  logic [W_SEL-1:0] src_q;
  logic             hit_q;

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      rgb_q   <= '0;
      src_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      rgb_q   <= rgb_d;
      src_q   <= src_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_rgb   = rgb_q;
  assign bus.o_src   = src_q;
  assign bus.o_hit   = hit_q;
  assign bus.o_phase = phase_q;
endmodule

// File: tb/tb_rgb_layer_mux.sv
// tb_rgb_layer_mux
// Table-driven check of rgb_layer_mux with N_CH = 9 and BLINK_FRAMES = 2.
// Hand-written sequences cover reset, latency, blinking and an asynchronous reset mid-stream.
module tb_rgb_layer_mux;
  localparam int N  = 9;
  localparam int W  = 12;
  localparam int WS = 4;

  typedef struct {
    logic          mode;
    logic [WS-1:0] sel;
    logic [N*W-1:0] rgb;
    logic [N-1:0]  en;
    logic          key_en;
    logic          blank;
    logic [W-1:0]  bg;
    logic [W-1:0]  exp_rgb;
    logic [WS-1:0] exp_src;
    logic          exp_hit;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];
  logic [N*W-1:0] ramp;
  logic [N*W-1:0] scene;

  always #5 clk = ~clk;

  rgb_layer_mux_if #(.N_CH(N), .W_RGB(W), .W_SEL(WS)) bus ();

  rgb_layer_mux #(
    .N_CH(N), .W_RGB(W), .W_SEL(WS), .KEY_RGB(12'hF0F), .BLINK_FRAMES(2)
  ) dut (
    .i_pclk(clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic vec_t mk(input logic mode, input logic [WS-1:0] sel,
                              input logic [N*W-1:0] rgb, input logic [N-1:0] en,
                              input logic key_en, input logic blank, input logic [W-1:0] bg,
                              input logic [W-1:0] er, input logic [WS-1:0] es, input logic eh);
    vec_t v;
    v.mode = mode; v.sel = sel; v.rgb = rgb; v.en = en; v.key_en = key_en;
    v.blank = blank; v.bg = bg; v.exp_rgb = er; v.exp_src = es; v.exp_hit = eh;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.i_valid      = 1'b1;
    bus.i_mode       = v.mode;
    bus.i_sel        = v.sel;
    bus.i_rgb        = v.rgb;
    bus.i_en         = v.en;
    bus.i_key_en     = v.key_en;
    bus.i_blank      = v.blank;
    bus.i_bg_rgb     = v.bg;
    bus.i_blink_mask = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_out"}, {27'd0, bus.o_valid, bus.o_hit, bus.o_src},
        32'd0);
    chk({name, "_rgb"}, {20'd0, bus.o_rgb}, 32'd0);
  endtask

  task automatic vs_pulse(input int n, input logic exp_phase);
    bus.i_vsync = 1'b1;
    step();
    bus.i_vsync = 1'b0;
    step();
    chk($sformatf("phase_edge%0d", n), {31'd0, bus.o_phase}, {31'd0, exp_phase});
  endtask

  initial begin
    logic [127:0] rnd;
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 0; k < N; k++) ramp[k*W +: W] = W'(12'h100 + k);
    scene = '0;
    scene[0*W +: W] = 12'h111;
    scene[5*W +: W] = 12'h555;
    scene[8*W +: W] = 12'hF0F;

    // ---- reset with random inputs ----
    bus.i_valid      = 1'b1;
    bus.i_blank      = 1'b0;
    bus.i_vsync      = 1'b0;
    bus.i_mode       = 1'($urandom_range(0, 1));
    bus.i_sel        = 4'($urandom_range(0, 15));
    bus.i_rgb        = rnd[N*W-1:0];
    bus.i_en         = 9'($urandom_range(0, 511));
    bus.i_key_en     = 1'($urandom_range(0, 1));
    bus.i_blink_mask = 9'($urandom_range(0, 511));
    bus.i_bg_rgb     = 12'($urandom_range(1, 4095));
    repeat (3) step();
    chk_zero("reset");
    chk("reset_phase", {31'd0, bus.o_phase}, 32'd0);
    bus.i_valid = 1'b0;
    bus.i_blank = 1'b1;
    rst = 1'b0;
    step();
    chk_zero("idle1");
    step();
    chk_zero("idle2");
    chk("idle_phase", {31'd0, bus.o_phase}, 32'd0);
    bus.i_valid = 1'b1;
    step();
    chk("latency_c1", {31'd0, bus.o_valid}, 32'd0);
    step();
    chk("latency_c2", {31'd0, bus.o_valid}, 32'd1);

    // ---- vector table ----
    for (int s = 0; s < 16; s++) begin
      if (s < N)
        vecs.push_back(mk(1'b0, 4'(s), ramp, 9'h1FF, 1'b0, 1'b0, 12'h000,
                          W'(12'h100 + s), 4'(s), 1'b1));
      else
        vecs.push_back(mk(1'b0, 4'(s), ramp, 9'h1FF, 1'b0, 1'b0, 12'h000,
                          12'h000, 4'd0, 1'b0));
    end
    vecs.push_back(mk(1'b1, 4'd0, scene, 9'h121, 1'b1, 1'b0, 12'h000, 12'h555, 4'd5, 1'b1));
    vecs.push_back(mk(1'b1, 4'd0, scene, 9'h121, 1'b0, 1'b0, 12'h000, 12'hF0F, 4'd8, 1'b1));
    vecs.push_back(mk(1'b1, 4'd0, scene, 9'h000, 1'b1, 1'b0, 12'h0A0, 12'h0A0, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 4'd8, scene, 9'h121, 1'b1, 1'b0, 12'h0A0, 12'h0A0, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 4'd5, scene, 9'h121, 1'b1, 1'b0, 12'h0A0, 12'h555, 4'd5, 1'b1));
    // Switch mode and blank on every pixel.
    vecs.push_back(mk(1'b0, 4'd3, ramp, 9'h1FF, 1'b0, 1'b1, 12'h0A0, 12'h000, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 4'd0, ramp, 9'h1FF, 1'b0, 1'b0, 12'h0A0, 12'h108, 4'd8, 1'b1));
    vecs.push_back(mk(1'b0, 4'd2, ramp, 9'h1FF, 1'b0, 1'b1, 12'h0A0, 12'h000, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 4'd0, ramp, 9'h00F, 1'b0, 1'b0, 12'h0A0, 12'h103, 4'd3, 1'b1));
    vecs.push_back(mk(1'b0, 4'd2, ramp, 9'h1FF, 1'b0, 1'b0, 12'h0A0, 12'h102, 4'd2, 1'b1));
    vecs.push_back(mk(1'b1, 4'd0, ramp, 9'h1FF, 1'b0, 1'b1, 12'h0A0, 12'h000, 4'd0, 1'b0));

    // A pixel applied before edge i appears after edge i+1, so check vector i-1 after edge i.
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i < vecs.size()) drive(vecs[i]);
      else bus.i_valid = 1'b0;
      step();
      if (i >= 1)
        chk($sformatf("vec%0d", i - 1),
            {14'd0, bus.o_valid, bus.o_hit, bus.o_src, bus.o_rgb},
            {14'd0, 1'b1, vecs[i-1].exp_hit, vecs[i-1].exp_src, vecs[i-1].exp_rgb});
    end

    // ---- blink with BLINK_FRAMES = 2 ----
    drive(mk(1'b1, 4'd0, scene, 9'h121, 1'b1, 1'b0, 12'h000, 12'h0, 4'd0, 1'b0));
    bus.i_blink_mask = 9'h020;
    vs_pulse(1, 1'b0);
    step();
    chk("blink_ph0", {16'd0, bus.o_src, bus.o_rgb}, {16'd0, 4'd5, 12'h555});
    vs_pulse(2, 1'b1);
    repeat (2) step();
    chk("blink_ph1", {16'd0, bus.o_src, bus.o_rgb}, {16'd0, 4'd0, 12'h111});
    vs_pulse(3, 1'b1);
    vs_pulse(4, 1'b0);
    repeat (2) step();
    chk("blink_ph0b", {16'd0, bus.o_src, bus.o_rgb}, {16'd0, 4'd5, 12'h555});
    vs_pulse(5, 1'b0);
    vs_pulse(6, 1'b1);
    vs_pulse(7, 1'b1);

    // ---- asynchronous reset mid-burst (counter is at 1, phase at 1) ----
    step();
    chk("pre_rst_valid", {31'd0, bus.o_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    chk("midrst_phase", {31'd0, bus.o_phase}, 32'd0);
    step();
    #2;
    rst = 1'b0;
    vs_pulse(1, 1'b0);
    vs_pulse(2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rgb_layer_mux.md
Name: rgb_layer_mux

Overview:
- Parametrised successor to the fixed 9-way sprite-ROM RGB selector.
- Sits between the per-object ROMs and the VGA output stage.
- Takes N_CH pixel streams and outputs one of two results:
  - mode 0: the directly selected channel;
  - mode 1: a priority composite of all enabled, non-transparent channels.
- Adds a colour key, a per-channel enable mask, frame-based blinking, a 2-stage pipeline with valid and blank tracking, and a source index for debug and collision logic.

Parameters:
- N_CH, 9, number of input channels; must be 2..16.
- W_RGB, 12, pixel width in bits.
- W_SEL, 4, select and source-index width; requires 2^W_SEL >= N_CH.
- KEY_RGB, 12'hF0F, transparent colour key.
- BLINK_FRAMES, 16, number of vsync rising edges per blink-phase toggle; must be >= 1.

Ports:
- i_pclk  in  1  pixel clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_valid  in  1  input pixel qualifier.
- i_blank  in  1  blanking interval flag, pipelined with the pixel.
- i_vsync  in  1  vertical sync; its rising edges are counted for blinking.
- i_mode  in  1  0 = direct select, 1 = priority overlay.
- i_sel  in  W_SEL  channel index used in mode 0.
- i_rgb  in  N_CH*W_RGB  flattened channel pixels; channel k occupies bits [k*W_RGB +: W_RGB].
- i_en  in  N_CH  per-channel enable mask.
- i_key_en  in  1  enables colour-key transparency.
- i_blink_mask  in  N_CH  channels hidden while blink phase = 1.
- i_bg_rgb  in  W_RGB  background colour.
- o_valid  out  1  output qualifier.
- o_rgb  out  W_RGB  output pixel.
- o_src  out  W_SEL  index of the winning channel; 0 when there is no hit.
- o_hit  out  1  1 when a channel supplied o_rgb.
- o_phase  out  1  current blink phase.

Behaviour:
- Reset (asynchronous, i_rst = 1):
  - all pipeline registers clear;
  - o_valid = 0, o_rgb = 0, o_src = 0, o_hit = 0, o_phase = 0;
  - blink counter = 0 and the vsync edge register = 0.
  - Reset asserted mid-frame drops all in-flight pixels. No output toggles until two valid cycles after release.
- Blink logic:
  - vs_q registers i_vsync every cycle; an edge is i_vsync & ~vs_q.
  - The counter is ceil(log2(BLINK_FRAMES)) bits wide and increments on each edge.
  - On the edge where the counter equals BLINK_FRAMES-1, the counter returns to 0 and o_phase toggles.
  - If BLINK_FRAMES = 1, o_phase toggles on every edge.
  - A new phase affects pixels entering stage 1 on the cycle after the edge.
- Stage 1 (registered every cycle regardless of i_valid; valid travels alongside the data):
  - opaque[k] = i_en[k] & ~(i_key_en & rgb_k == KEY_RGB) & ~(i_blink_mask[k] & o_phase).
  - Registers the rgb bus, opaque vector, mode, sel, blank, bg and valid.
- Stage 2:
  - Mode 0, sel >= N_CH: o_rgb = 0, o_hit = 0, o_src = 0 (same default-0 behaviour as before).
  - Mode 0, sel in range and opaque[sel]: o_rgb = rgb_sel, o_hit = 1, o_src = sel.
  - Mode 0, sel in range and not opaque: o_rgb = bg, o_hit = 0, o_src = 0.
  - Mode 1: the highest-index opaque channel wins (channel N_CH-1 has top priority); o_rgb = its pixel, o_src = its index, o_hit = 1.
  - Mode 1 with no opaque channel: o_rgb = bg, o_hit = 0, o_src = 0.
  - Blank overrides everything: o_rgb = 0, o_hit = 0, o_src = 0.
  - o_valid = stage-1 valid.
- Latency and throughput:
  - Latency is exactly 2 cycles from input to o_*.
  - One pixel per cycle, no backpressure.
  - Mode, sel, en and mask changes apply per pixel, aligned with the pixel they accompany; there is no glitch between adjacent pixels.
- When i_valid = 0, data still flows through the pipeline, but o_valid = 0 marks it don't-care.

Test Plan:
- Reset: assert i_rst with random inputs, release, hold i_valid = 0 → o_valid = 0, o_rgb = 0, o_src = 0, o_hit = 0, o_phase = 0; first valid pixel appears at o_valid exactly 2 cycles after i_valid rises.
- Mode 0 sweep (N_CH = 9): channel k = 12'h100+k, all enabled, sel = 0..8 → o_rgb = 12'h100+sel, o_src = sel, o_hit = 1; sel = 9..15 → o_rgb = 0, o_hit = 0.
- Mode 1 priority and key: ch0 = 12'h111, ch5 = 12'h555, ch8 = KEY_RGB, others disabled, i_key_en = 1 → o_rgb = 12'h555, o_src = 5. With i_key_en = 0 → o_rgb = 12'hF0F, o_src = 8. All disabled, bg = 12'h0A0 → o_rgb = 12'h0A0, o_hit = 0.
- Blink (BLINK_FRAMES = 2): blink_mask = bit 5, mode 1 scene as above → o_phase toggles after vsync rising edges 2, 4 and 6. While phase = 1, o_rgb = 12'h111 and o_src = 0.
- Blank and per-pixel switch: alternate mode 0/1 and i_blank every cycle → each output matches the expected value for its own input pixel, 2 cycles delayed; every blanked pixel gives o_rgb = 0.
- Reset mid-stream: pulse i_rst asynchronously between clock edges during a valid burst → outputs clear immediately; o_phase = 0 and the blink counter restarts from 0.
